// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: fixed-priority grant of one reservation-station result per cycle into a
// registered CDB stage. Optional aging promotion is compiled in with `define CDB_ARBITER_AGING_EN.

package expipe_pkg;

    typedef struct packed {
        logic [5:0]  rob_idx;
        logic [31:0] res_value;
        logic        except_raised;
        logic [4:0]  except_code;
    } cdb_data_t;

endpackage

module cdb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int AGE_THR = 8
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  flush_i,
    input  logic [NUM_REQ-1:0]                    rs_valid_i,
    output logic [NUM_REQ-1:0]                    rs_ready_o,
    input  expipe_pkg::cdb_data_t [NUM_REQ-1:0]   rs_data_i,
    input  logic                                  rob_ready_i,
    output logic                                  cdb_valid_o,
    output expipe_pkg::cdb_data_t                 cdb_data_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic                   valid_q;
    logic                   valid_d;
    expipe_pkg::cdb_data_t  data_q;
    expipe_pkg::cdb_data_t  data_d;

    logic                   slot_free_s;
    logic                   grant_en_s;
    logic                   grant_any_s;
    logic                   win_any_s;
    logic [IDX_W-1:0]       win_idx_s;
    logic [NUM_REQ-1:0]     promo_s;

`ifdef CDB_ARBITER_AGING_EN
    localparam int AGE_W = $clog2(AGE_THR + 1);

    logic [NUM_REQ-1:0][AGE_W-1:0] age_q;
    logic [NUM_REQ-1:0][AGE_W-1:0] age_d;

    // Age counters: cleared on grant, idle or flush; otherwise saturate at the threshold.
    always_comb begin
        age_d   = age_q;
        promo_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            promo_s[i] = rs_valid_i[i] & (age_q[i] == AGE_W'(AGE_THR));
            if (flush_i || !rs_valid_i[i] || rs_ready_o[i]) begin
                age_d[i] = '0;
            end else if (age_q[i] != AGE_W'(AGE_THR)) begin
                age_d[i] = age_q[i] + AGE_W'(1);
            end else begin
                age_d[i] = age_q[i];
            end
        end
    end

    // Age counter state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end
`else
    // Pure fixed priority: nobody is ever promoted.
    always_comb begin
        promo_s = '0;
    end
`endif

    // Winner: promoted requesters first, then lowest valid index.
    always_comb begin
        win_idx_s = '0;
        win_any_s = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            win_idx_s = rs_valid_i[i] ? IDX_W'(i) : win_idx_s;
            win_any_s = win_any_s | rs_valid_i[i];
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            win_idx_s = promo_s[i] ? IDX_W'(i) : win_idx_s;
        end
    end

    // Grant generation; rob_ready_i reaches rs_ready_o combinationally through slot_free_s.
    always_comb begin
        slot_free_s            = !valid_q | rob_ready_i;
        grant_en_s             = slot_free_s & !flush_i;
        grant_any_s            = grant_en_s & win_any_s;
        rs_ready_o             = '0;
        rs_ready_o[win_idx_s]  = grant_any_s;
    end

    // Output stage next state: flush beats grant, grant beats drain; data survives drain/flush.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (grant_any_s) begin
            valid_d = 1'b1;
            data_d  = rs_data_i[win_idx_s];
        end else if (rob_ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Output stage register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign cdb_valid_o = valid_q;
    assign cdb_data_o  = data_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: stimulus queues expected CDB words, a monitor pops them on
// every accepted CDB beat. Expectations follow CDB_ARBITER_AGING_EN when it is defined.

module tb_cdb_arbiter;
    import expipe_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic [3:0]        rs_valid;
    logic [3:0]        rs_ready;
    cdb_data_t [3:0]   rs_data;
    logic              rob_ready;
    logic              cdb_valid;
    cdb_data_t         cdb_data;

    cdb_data_t         sb[$];
    int                n_vec = 0;
    int                n_err = 0;

    cdb_arbiter #(.NUM_REQ(4), .AGE_THR(8)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .rs_valid_i  (rs_valid),
        .rs_ready_o  (rs_ready),
        .rs_data_i   (rs_data),
        .rob_ready_i (rob_ready),
        .cdb_valid_o (cdb_valid),
        .cdb_data_o  (cdb_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic cdb_data_t mk(input int rob, input logic [31:0] val,
                                     input logic exc, input logic [4:0] code);
        cdb_data_t w;
        w.rob_idx       = rob[5:0];
        w.res_value     = val;
        w.except_raised = exc;
        w.except_code   = code;
        return w;
    endfunction

    // Expected winner in the aging scenario: req 3 every ninth cycle when aging is built in.
    function automatic int aging_winner(input int c);
`ifdef CDB_ARBITER_AGING_EN
        return ((c % 9) == 8) ? 3 : 0;
`else
        return 0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Monitor: every word the ROB accepts must be the next expected one.
    initial begin
        cdb_data_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && cdb_valid === 1'b1 && rob_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_cdb_word", 64'(cdb_data), 64'h0);
                end else begin
                    e = sb.pop_front();
                    check("cdb_word", 64'(cdb_data), 64'(e));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cdb_data_t w1, w2, w5, w0, wf, w3, we, wa, wz;
        int        exp_w, hits3, exp_hits3;

        rst_n     = 1'b0;
        flush     = 1'b0;
        rs_valid  = 4'b0000;
        rob_ready = 1'b0;
        rs_data   = '0;
        w1 = mk(1,  32'h1111_0001, 1'b0, 5'd0);
        w2 = mk(2,  32'h2222_0002, 1'b0, 5'd0);
        w5 = mk(5,  32'h5555_0005, 1'b0, 5'd0);
        w0 = mk(10, 32'hA0A0_000A, 1'b0, 5'd0);
        wf = mk(20, 32'hF1F1_0014, 1'b0, 5'd0);
        w3 = mk(33, 32'h3333_0021, 1'b0, 5'd0);
        we = mk(9,  32'hDEAD_BEEF, 1'b1, 5'd2);
        wa = mk(40, 32'hAAAA_0028, 1'b0, 5'd0);
        wz = mk(63, 32'hCCCC_003F, 1'b0, 5'd0);

        smp();
        check("reset_valid", 64'(cdb_valid), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;

        // Idle after reset.
        for (int i = 0; i < 10; i++) begin
            smp();
            check("idle_valid", 64'(cdb_valid), 64'd0);
            check("idle_data",  64'(cdb_data),  64'd0);
            check("idle_ready", 64'(rs_ready),  64'd0);
            tick();
        end

        // Two requesters, back-to-back throughput.
        rob_ready  = 1'b1;
        rs_data[1] = w1;
        rs_data[2] = w2;
        rs_valid   = 4'b0110;
        sb.push_back(w1);
        sb.push_back(w2);
        smp(); check("prio_c0_ready", 64'(rs_ready), 64'b0010); tick();
        rs_valid = 4'b0100;
        smp(); check("prio_c1_ready", 64'(rs_ready), 64'b0100);
        check("prio_c1_valid", 64'(cdb_valid), 64'd1); tick();
        rs_valid = 4'b0000;
        smp(); check("prio_c2_data", 64'(cdb_data), 64'(w2));
        check("prio_c2_ready", 64'(rs_ready), 64'd0); tick();
        smp(); check("prio_c3_valid", 64'(cdb_valid), 64'd0); tick();

        // ROB backpressure holds the word and blocks grants.
        rs_data[1] = w5;
        rs_valid   = 4'b0010;
        sb.push_back(w5);
        smp(); check("bp_load_ready", 64'(rs_ready), 64'b0010); tick();
        rs_valid   = 4'b0001;
        rs_data[0] = w0;
        rob_ready  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            smp();
            check("bp_ready",   64'(rs_ready),         64'd0);
            check("bp_rob_idx", 64'(cdb_data.rob_idx), 64'd5);
            check("bp_valid",   64'(cdb_valid),        64'd1);
            tick();
        end
        rob_ready = 1'b1;
        sb.push_back(w0);
        smp(); check("bp_release_ready", 64'(rs_ready), 64'b0001); tick();
        rs_valid = 4'b0000;
        smp(); check("bp_next_data", 64'(cdb_data), 64'(w0)); tick();
        smp(); check("bp_drained", 64'(cdb_valid), 64'd0); tick();

        // Flush with a word on the CDB and req 3 waiting.
        rs_data[1] = wf;
        rs_valid   = 4'b0010;
        sb.push_back(wf);
        smp(); check("fl_load_ready", 64'(rs_ready), 64'b0010); tick();
        rs_valid   = 4'b1000;
        rs_data[3] = w3;
        flush      = 1'b1;
        smp(); check("fl_ready", 64'(rs_ready), 64'd0);
        check("fl_valid_before", 64'(cdb_valid), 64'd1); tick();
        flush = 1'b0;
        sb.push_back(w3);
        smp(); check("fl_valid_after", 64'(cdb_valid), 64'd0);
        check("fl_regrant", 64'(rs_ready), 64'b1000); tick();
        rs_valid = 4'b0000;
        smp(); check("fl_word", 64'(cdb_data), 64'(w3)); tick();
        smp(); tick();

        // Exception fields pass through.
        rs_data[2] = we;
        rs_valid   = 4'b0100;
        sb.push_back(we);
        smp(); check("exc_ready", 64'(rs_ready), 64'b0100); tick();
        rs_valid = 4'b0000;
        smp(); check("exc_raised", 64'(cdb_data.except_raised), 64'd1);
        check("exc_code", 64'(cdb_data.except_code), 64'd2); tick();
        smp(); tick();

        // Aging: req 0 always valid, req 3 continuously valid.
        rs_data[0] = wa;
        rs_data[3] = wz;
        rs_valid   = 4'b1001;
        hits3      = 0;
        exp_hits3  = 0;
        for (int c = 0; c < 100; c++) begin
            exp_w = aging_winner(c);
            if (exp_w == 3) begin
                sb.push_back(wz);
                exp_hits3++;
            end else begin
                sb.push_back(wa);
            end
            smp();
            check("age_ready", 64'(rs_ready), 64'(4'b0001 << exp_w));
            if (rs_ready[3] === 1'b1) begin
                hits3++;
            end else begin
                hits3 = hits3;
            end
            tick();
        end
        rs_valid = 4'b0000;
        smp(); check("age_req3_count", 64'(hits3), 64'(exp_hits3)); tick();
        repeat (3) begin
            smp(); tick();
        end

        check("sb_leftover", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
